vres_reader: RTL

VRES_READER -- requirements
Module: vres_reader

---
 rtl/vres_reader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vres_reader.sv
// Result-BRAM reader: streams DEPTH words from a synchronous-read BRAM onto a
// valid/ready stream. Reads run ahead of the consumer through a 2-entry FIFO
// so that full throughput is kept despite the one-cycle BRAM read latency.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; indices, FIFO and inflight held cleared
// RUN     | issuing reads and streaming results until the last pop
// DONE    | single-cycle done pulse, then back to IDLE
module vres_reader #(
  parameter int DEPTH = 100,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  // One spare bit so the read index can sit at DEPTH once all reads are issued.
  localparam int IW = AW + 1;
  localparam logic [IW-1:0] DEPTH_I = IW'(DEPTH);
  localparam logic [IW-1:0] LAST_I  = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [1:0]    count_q, count_d;
  logic          inflight_q, inflight_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] fifo_d [2];

  logic          push;
  logic          pop;
  logic [1:0]    occupancy;

  // Registered state; reset discards any buffered or in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_q     <= fifo_d;
    end
  end

  // Outputs and read issue: a read may go out whenever the data already held
  // or in flight leaves a free slot, counting the slot a pop frees this cycle.
  always_comb begin
    m_valid   = (count_q != 2'd0);
    m_data    = m_valid ? fifo_q[rd_ptr_q] : '0;
    pop       = m_valid && m_ready;
    push      = inflight_q;
    m_last    = m_valid && (out_idx_q == LAST_I);
    occupancy = count_q + {1'b0, inflight_q};
    rd_en     = (state_q == ST_RUN) && (rd_idx_q < DEPTH_I) &&
                ((occupancy < 2'd2) || pop);
    rd_addr   = rd_en ? rd_idx_q[AW-1:0] : '0;
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  // Next-state: sequencing, index advance and FIFO push/pop bookkeeping.
  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    out_idx_d  = out_idx_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_d     = fifo_q;

    case (state_q)
      ST_IDLE: begin
        rd_idx_d   = '0;
        out_idx_d  = '0;
        count_d    = '0;
        inflight_d = 1'b0;
        wr_ptr_d   = 1'b0;
        rd_ptr_d   = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        inflight_d = rd_en;
        if (rd_en) begin
          rd_idx_d = rd_idx_q + IW'(1);
        end
        if (push) begin
          fifo_d[wr_ptr_q] = rd_data;
          wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_d  = ~rd_ptr_q;
          out_idx_d = out_idx_q + IW'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + 2'd1;
          2'b01:   count_d = count_q - 2'd1;
          default: count_d = count_q;
        endcase
        if (pop && m_last) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        inflight_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
